// File: rtl/alu_sched_pkg.sv
// Shared constants and state type for the ALU issue scheduler.
// Holds the instruction field positions, the slot count and the FSM state encoding.
package alu_sched_pkg;
   localparam int DW      = 24;
   localparam int NSLOT   = 8;
   localparam int AW      = 3;
   localparam int CW      = 4;
   localparam int R_BIT   = 23;
   localparam int C_BIT   = 22;
   localparam int ADDR_HI = 21;
   localparam int ADDR_LO = 19;
   localparam int CMD_HI  = 18;
   localparam int CMD_LO  = 16;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      SCAN    = 2'd1,
      ISSUE   = 2'd2,
      DONE    = 2'd3
   } state_e;
endpackage

// File: rtl/alu_issue_sched_prienc.sv
// Find-first-set over the live-slot mask, starting at a given pointer.
// more_above reports any set bit strictly above the start pointer.
module slot_prienc
   import alu_sched_pkg::*;
(
   input  logic [NSLOT-1:0] mask,
   input  logic [AW-1:0]    start,
   output logic             found,
   output logic [AW-1:0]    idx,
   output logic             more_above
);

   // Scanning downward lets the lowest qualifying index win.
   always_comb begin
      found      = 1'b0;
      idx        = '0;
      more_above = 1'b0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (mask[i] && (AW'(i) >= start)) begin
            found = 1'b1;
            idx   = AW'(i);
         end
         if (mask[i] && (AW'(i) > start)) begin
            more_above = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_issue_sched.sv
// Captures host instruction words into 8 slots and issues the live slots to
// the ALU in ascending order over a back-pressurable valid/ready handshake.
//
// state   | meaning
// CAPTURE | idle; host words accepted, slots written or cleared
// SCAN    | find the next live slot at or above ptr
// ISSUE   | offer slot rd_addr to the ALU until accepted
// DONE    | one-cycle end-of-run pulse, then back to CAPTURE
module alu_issue_sched
   import alu_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             cap_en,
   output logic [AW-1:0]    cap_addr,
   output logic [AW-1:0]    rd_addr,
   output logic             iss_valid,
   input  logic             iss_ready,
   output logic             iss_last,
   output logic [NSLOT-1:0] slot_valid,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    issued_cnt
);

   state_e           state_q, state_d;
   logic [NSLOT-1:0] slot_valid_q, slot_valid_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic [AW-1:0]    pe_start;
   logic             pe_found;
   logic [AW-1:0]    pe_idx;
   logic             pe_more;

   // The operand/command fields go straight to the source register, not here.
   logic unused_data;
   assign unused_data = ^in_data[CMD_HI:0];

   assign in_ready   = (state_q == CAPTURE);
   assign accept     = in_valid & in_ready;
   assign cap_addr   = in_data[ADDR_HI:ADDR_LO];
   assign cap_en     = accept & ~in_data[C_BIT];
   assign busy       = (state_q != CAPTURE);
   assign rd_addr    = rd_addr_q;
   assign slot_valid = slot_valid_q;
   assign issued_cnt = cnt_q;

   // One encoder serves both states: SCAN searches from ptr, ISSUE asks
   // whether anything lives above the slot currently offered.
   assign pe_start = (state_q == ISSUE) ? rd_addr_q : ptr_q;

   slot_prienc u_prienc (
      .mask       (slot_valid_q),
      .start      (pe_start),
      .found      (pe_found),
      .idx        (pe_idx),
      .more_above (pe_more)
   );

   always_comb begin
      state_d      = state_q;
      slot_valid_d = slot_valid_q;
      ptr_d        = ptr_q;
      rd_addr_d    = rd_addr_q;
      cnt_d        = cnt_q;
      iss_valid    = 1'b0;
      iss_last     = 1'b0;
      done         = 1'b0;
      case (state_q)
         CAPTURE: begin
            if (accept) begin
               slot_valid_d[cap_addr] = ~in_data[C_BIT];
               if (in_data[R_BIT]) begin
                  state_d = SCAN;
                  ptr_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         SCAN: begin
            if (pe_found) begin
               rd_addr_d = pe_idx;
               state_d   = ISSUE;
            end else begin
               state_d = DONE;
            end
         end
         ISSUE: begin
            iss_valid = 1'b1;
            iss_last  = ~pe_more;
            if (iss_ready) begin
               slot_valid_d[rd_addr_q] = 1'b0;
               cnt_d = cnt_q + CW'(1);
               if ((rd_addr_q == AW'(NSLOT - 1)) || !pe_more) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = rd_addr_q + AW'(1);
                  state_d = SCAN;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            ptr_d   = '0;
            state_d = CAPTURE;
         end
         default: state_d = CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CAPTURE;
         slot_valid_q <= '0;
         ptr_q        <= '0;
         rd_addr_q    <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         slot_valid_q <= slot_valid_d;
         ptr_q        <= ptr_d;
         rd_addr_q    <= rd_addr_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule
